// File: rtl/module_keypad_scan.sv
// Keypad scan controller: paces an external column counter through its stop
// input, debounces the row under the active column and reports one code per press.
module module_keypad_scan #(
    parameter int SCAN_PERIOD     = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_sel,
    input  logic [3:0] row_n,
    output logic       stop,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam int DW  = $clog2(SCAN_PERIOD);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_PERIOD - 1);
    localparam logic [DBW-1:0] DEB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     sync1_q, sync1_d;
    logic [3:0]     rs_q, rs_d;
    logic [DW-1:0]  dwell_q, dwell_d;
    logic [DBW-1:0] deb_q, deb_d;
    logic [1:0]     row_idx_q, row_idx_d;
    logic [1:0]     col_idx_q, col_idx_d;
    logic [3:0]     key_code_q, key_code_d;
    logic           key_valid_q, key_valid_d;
    logic           key_held_q, key_held_d;
    logic           stop_q, stop_d;

    logic           any_active;
    logic           col_onehot;
    logic           row_low;
    logic [1:0]     low_row;
    logic [1:0]     col_enc;

    // Lowest-index active row wins when several rows are pulled low together.
    always_comb begin
        any_active = (rs_q != 4'hF);
        col_onehot = $onehot(col_sel);
        row_low    = ~rs_q[row_idx_q];
        if (!rs_q[0])      low_row = 2'd0;
        else if (!rs_q[1]) low_row = 2'd1;
        else if (!rs_q[2]) low_row = 2'd2;
        else               low_row = 2'd3;
        case (col_sel)
            4'b0010: col_enc = 2'd1;
            4'b0100: col_enc = 2'd2;
            4'b1000: col_enc = 2'd3;
            default: col_enc = 2'd0;
        endcase
    end

    always_comb begin
        sync1_d     = row_n;
        rs_d        = sync1_q;
        state_d     = state_q;
        dwell_d     = dwell_q;
        deb_d       = deb_q;
        row_idx_d   = row_idx_q;
        col_idx_d   = col_idx_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        stop_d      = 1'b1;

        case (state_q)
            SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    if (any_active && col_onehot) begin
                        row_idx_d = low_row;
                        col_idx_d = col_enc;
                        deb_d     = '0;
                        state_d   = DEBOUNCE;
                    end else begin
                        stop_d  = 1'b0;
                        dwell_d = '0;
                    end
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            DEBOUNCE: begin
                if (!row_low) begin
                    state_d = SCAN;
                    dwell_d = '0;
                end else if (deb_q == DEB_LAST) begin
                    key_code_d  = {row_idx_q, col_idx_q};
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                    state_d     = HELD;
                end else begin
                    deb_d = deb_q + DBW'(1);
                end
            end
            HELD: begin
                if (!row_low) begin
                    deb_d   = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                // Leaving on a debounced release also steps the column on.
                if (row_low) begin
                    state_d = HELD;
                end else if (deb_q == DEB_LAST) begin
                    key_held_d = 1'b0;
                    stop_d     = 1'b0;
                    dwell_d    = '0;
                    state_d    = SCAN;
                end else begin
                    deb_d = deb_q + DBW'(1);
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= SCAN;
            sync1_q     <= 4'hF;
            rs_q        <= 4'hF;
            dwell_q     <= '0;
            deb_q       <= '0;
            row_idx_q   <= 2'd0;
            col_idx_q   <= 2'd0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            stop_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            rs_q        <= rs_d;
            dwell_q     <= dwell_d;
            deb_q       <= deb_d;
            row_idx_q   <= row_idx_d;
            col_idx_q   <= col_idx_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            stop_q      <= stop_d;
        end
    end

    assign stop      = stop_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule
